// File: rtl/ws2812_bit_encoder.sv
// One-wire LED serializer: 24-bit pixels in over valid/ready, NRZ pulse-width bits out MSB first,
// plus the low latch period on request. Optional underrun counter under WS2812_ENC_UNDERRUN_CNT_EN.
module ws2812_bit_encoder #(
   parameter int unsigned N_BITS       = 24,
   parameter int unsigned T0H_CYCLES   = 8,
   parameter int unsigned T1H_CYCLES   = 16,
   parameter int unsigned BIT_CYCLES   = 25,
   parameter int unsigned LATCH_CYCLES = 6000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BITS-1:0] pixel_data,
   input  logic              pixel_valid,
   output logic              pixel_ready,
   input  logic              frame_end,
   output logic              busy,
   output logic              led_sdi
`ifdef WS2812_ENC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_count
`endif
);

   localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
   localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);
   localparam int unsigned IDX_W = $clog2(N_BITS);

   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES
         && LATCH_CYCLES >= BIT_CYCLES && N_BITS >= 2)) begin : g_param_check
      $error("ws2812_bit_encoder: illegal timing parameters");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_LATCH} state_e;

   state_e             state_q;
   logic [N_BITS-1:0]  shift_q;
   logic [IDX_W-1:0]   bit_idx_q;
   logic [CYC_W-1:0]   cyc_q;
   logic [LAT_W-1:0]   latch_cnt_q;
   logic               latch_pending_q;
   logic               led_sdi_q;
`ifdef WS2812_ENC_UNDERRUN_CNT_EN
   logic [15:0]        underrun_q;
`endif

   logic bit_last_c;
   logic pixel_last_c;
   logic accept_c;

   // Handshake decoded from state registers only; a pending latch holds off the next pixel.
   assign bit_last_c   = (cyc_q == CYC_W'(BIT_CYCLES - 1));
   assign pixel_last_c = (state_q == ST_SEND) && bit_last_c && (bit_idx_q == '0);
   assign pixel_ready  = !reset && ((state_q == ST_IDLE) || (pixel_last_c && !latch_pending_q));
   assign accept_c     = pixel_valid && pixel_ready;
   assign busy         = (state_q != ST_IDLE) || latch_pending_q;
   assign led_sdi      = led_sdi_q;
`ifdef WS2812_ENC_UNDERRUN_CNT_EN
   assign underrun_count = underrun_q;
`endif

   function automatic logic hi_level(input logic [CYC_W-1:0] c, input logic data_bit);
      return c < (data_bit ? CYC_W'(T1H_CYCLES) : CYC_W'(T0H_CYCLES));
   endfunction

   // led_sdi_q is loaded with the level of the cycle being entered so it lines up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         shift_q         <= '0;
         bit_idx_q       <= '0;
         cyc_q           <= '0;
         latch_cnt_q     <= '0;
         latch_pending_q <= 1'b0;
         led_sdi_q       <= 1'b0;
`ifdef WS2812_ENC_UNDERRUN_CNT_EN
         underrun_q      <= '0;
`endif
      end else begin
         led_sdi_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  state_q         <= ST_SEND;
                  shift_q         <= pixel_data;
                  bit_idx_q       <= IDX_W'(N_BITS - 1);
                  cyc_q           <= '0;
                  latch_pending_q <= frame_end;
                  led_sdi_q       <= hi_level('0, pixel_data[N_BITS-1]);
               end else if (frame_end) begin
                  state_q     <= ST_LATCH;
                  latch_cnt_q <= '0;
               end
            end
            ST_SEND: begin
               if (frame_end) latch_pending_q <= 1'b1;
               if (!bit_last_c) begin
                  cyc_q     <= cyc_q + CYC_W'(1);
                  led_sdi_q <= hi_level(cyc_q + CYC_W'(1), shift_q[N_BITS-1]);
               end else if (bit_idx_q != '0) begin
                  cyc_q     <= '0;
                  bit_idx_q <= bit_idx_q - IDX_W'(1);
                  shift_q   <= {shift_q[N_BITS-2:0], 1'b0};
                  led_sdi_q <= hi_level('0, shift_q[N_BITS-2]);
               end else if (latch_pending_q) begin
                  state_q         <= ST_LATCH;
                  latch_pending_q <= 1'b0;
                  latch_cnt_q     <= '0;
               end else if (accept_c) begin
                  // Gapless reload: next pixel's MSB starts on the following cycle.
                  shift_q         <= pixel_data;
                  bit_idx_q       <= IDX_W'(N_BITS - 1);
                  cyc_q           <= '0;
                  latch_pending_q <= frame_end;
                  led_sdi_q       <= hi_level('0, pixel_data[N_BITS-1]);
               end else if (frame_end) begin
                  state_q         <= ST_LATCH;
                  latch_pending_q <= 1'b0;
                  latch_cnt_q     <= '0;
               end else begin
                  state_q <= ST_IDLE;
                  cyc_q   <= '0;
`ifdef WS2812_ENC_UNDERRUN_CNT_EN
                  if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
`endif
               end
            end
            ST_LATCH: begin
               if (latch_cnt_q == LAT_W'(LATCH_CYCLES - 1)) begin
                  state_q     <= ST_IDLE;
                  latch_cnt_q <= '0;
               end else begin
                  latch_cnt_q <= latch_cnt_q + LAT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
